// File: rtl/digital_core_chain.sv
// rtl/digital_core_chain.sv - WIDTH-bit bidirectional scan chain with capture, shadow update and shift counter
module digital_core_chain #(
    parameter int             WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int            CW      = $clog2(WIDTH + 1)
) (
    input  logic             internal_clk,
    input  logic             dc_rst,
    input  logic             dc_clk_enable,
    input  logic [1:0]       dc_mode,
    input  logic             dc_dir,
    input  logic             dc_digital_input,
    input  logic [WIDTH-1:0] dc_parallel_in,
    output logic             dc_digital_output,
    output logic [WIDTH-1:0] dc_parallel_out,
    output logic [CW-1:0]    dc_shift_count,
    output logic             dc_shift_done
);

    localparam logic [1:0] MODE_HOLD    = 2'b00;
    localparam logic [1:0] MODE_SHIFT   = 2'b01;
    localparam logic [1:0] MODE_CAPTURE = 2'b10;
    localparam logic [1:0] MODE_UPDATE  = 2'b11;

    // Count saturates at CNT_MAX; the step from CNT_LAST is the only one that fires done.
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shadow;
    logic [CW-1:0]    count;
    logic             done;

    // Shift/capture/update state; done is a single-cycle pulse cleared on every edge.
    always_ff @(posedge internal_clk or posedge dc_rst) begin
        if (dc_rst) begin
            sreg   <= RST_VAL;
            shadow <= RST_VAL;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (dc_clk_enable) begin
                case (dc_mode)
                    MODE_SHIFT: begin
                        if (dc_dir)
                            sreg <= {dc_digital_input, sreg[WIDTH-1:1]};
                        else
                            sreg <= {sreg[WIDTH-2:0], dc_digital_input};
                        if (count != CNT_MAX) begin
                            count <= count + 1'b1;
                            if (count == CNT_LAST)
                                done <= 1'b1;
                        end
                    end
                    MODE_CAPTURE: begin
                        sreg  <= dc_parallel_in;
                        count <= '0;
                    end
                    MODE_UPDATE: begin
                        shadow <= sreg;
                        count  <= '0;
                    end
                    MODE_HOLD: ;
                    default: ;
                endcase
            end
        end
    end

    // Serial output taps the end of the chain the data is moving toward.
    always_comb begin
        dc_digital_output = dc_dir ? sreg[0] : sreg[WIDTH-1];
    end

    assign dc_parallel_out = shadow;
    assign dc_shift_count  = count;
    assign dc_shift_done   = done;

endmodule
